// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one request/ack bus.
// Optional bus-ack timeout is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter bit          LS_PRIO     = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  // load/store port
  input  logic        ls_req_i,
  input  logic        ls_wen_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  input  logic [3:0]  ls_wmask_i,
  output logic [31:0] ls_rdata_o,
  output logic        ls_ack_o,
  // shared bus
  output logic        bus_sel_o,
  output logic        bus_wen_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wmask_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  // status
  output logic        busy_o,
  output logic        err_o
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYC must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_LS = 2'd2
  } state_e;

  state_e      state_q,     state_d;
  logic        bus_sel_q,   bus_sel_d;
  logic        bus_wen_q,   bus_wen_d;
  logic [31:0] bus_addr_q,  bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wmask_q, bus_wmask_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic        if_ack_q,    if_ack_d;
  logic [31:0] ls_rdata_q,  ls_rdata_d;
  logic        ls_ack_q,    ls_ack_d;
  logic        busy_q,      busy_d;
  logic        last_ls_q,   last_ls_d;

  logic        done;
  logic [31:0] done_rdata;
  logic        ls_wins;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // LS wins a tie under fixed priority, or under round-robin when fetch had the last grant.
  assign ls_wins = ls_req_i && (!if_req_i || LS_PRIO || !last_ls_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    bus_sel_d   = bus_sel_q;
    bus_wen_d   = bus_wen_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wmask_d = bus_wmask_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    busy_d      = busy_q;
    last_ls_d   = last_ls_q;
    done        = 1'b0;
    done_rdata  = bus_rdata_i;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (ls_wins) begin
          state_d     = GRANT_LS;
          bus_sel_d   = 1'b1;
          busy_d      = 1'b1;
          bus_wen_d   = ls_wen_i;
          bus_addr_d  = ls_addr_i;
          bus_wdata_d = ls_wdata_i;
          bus_wmask_d = ls_wmask_i;
          last_ls_d   = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end else if (if_req_i) begin
          state_d     = GRANT_IF;
          bus_sel_d   = 1'b1;
          busy_d      = 1'b1;
          bus_wen_d   = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = 32'h0;
          bus_wmask_d = 4'b0000;
          last_ls_d   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end
      end
      GRANT_IF, GRANT_LS: begin
        if (bus_ack_i) begin
          done = 1'b1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          done       = 1'b1;
          done_rdata = 32'hDEAD_BEEF;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Bus address/data are left as captured; only sel drops when a transfer ends.
    if (done) begin
      state_d   = IDLE;
      bus_sel_d = 1'b0;
      busy_d    = 1'b0;
      if (state_q == GRANT_LS) begin
        ls_rdata_d = done_rdata;
        ls_ack_d   = 1'b1;
      end else begin
        if_rdata_d = done_rdata;
        if_ack_d   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_sel_q   <= 1'b0;
      bus_wen_q   <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_wmask_q <= 4'b0000;
      if_rdata_q  <= 32'h0;
      if_ack_q    <= 1'b0;
      ls_rdata_q  <= 32'h0;
      ls_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      last_ls_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_sel_q   <= bus_sel_d;
      bus_wen_q   <= bus_wen_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
      if_rdata_q  <= if_rdata_d;
      if_ack_q    <= if_ack_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_ack_q    <= ls_ack_d;
      busy_q      <= busy_d;
      last_ls_q   <= last_ls_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus_sel_o   = bus_sel_q;
  assign bus_wen_o   = bus_wen_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_wmask_o = bus_wmask_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_ack_o    = ls_ack_q;
  assign busy_o      = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 1 uses fixed LS priority, instance 0 round-robin.
// Expected transfers are queued when requests are driven and checked as the bus/ack side responds.
module tb_mem_arbiter;

  typedef struct {
    bit          is_ls;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req  [2];
  logic        ls_req  [2];
  logic        bus_ack [2];
  logic        ls_wen;
  logic [31:0] if_addr, ls_addr, ls_wdata, bus_rdata;
  logic [3:0]  ls_wmask;

  logic [31:0] if_rdata  [2];
  logic [31:0] ls_rdata  [2];
  logic        if_ack    [2];
  logic        ls_ack    [2];
  logic        bus_sel   [2];
  logic        bus_wen   [2];
  logic [31:0] bus_addr  [2];
  logic [31:0] bus_wdata [2];
  logic [3:0]  bus_wmask [2];
  logic        busy      [2];
  logic        err       [2];

  txn_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LS_PRIO(1'b1), .TIMEOUT_CYC(8)) u_prio (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[1]), .if_addr_i(if_addr), .if_rdata_o(if_rdata[1]), .if_ack_o(if_ack[1]),
    .ls_req_i(ls_req[1]), .ls_wen_i(ls_wen), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_wmask_i(ls_wmask), .ls_rdata_o(ls_rdata[1]), .ls_ack_o(ls_ack[1]),
    .bus_sel_o(bus_sel[1]), .bus_wen_o(bus_wen[1]), .bus_addr_o(bus_addr[1]),
    .bus_wdata_o(bus_wdata[1]), .bus_wmask_o(bus_wmask[1]), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack[1]), .busy_o(busy[1]), .err_o(err[1])
  );

  mem_arbiter #(.LS_PRIO(1'b0), .TIMEOUT_CYC(8)) u_rr (
    .clk(clk), .rst(rst),
    .if_req_i(if_req[0]), .if_addr_i(if_addr), .if_rdata_o(if_rdata[0]), .if_ack_o(if_ack[0]),
    .ls_req_i(ls_req[0]), .ls_wen_i(ls_wen), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_wmask_i(ls_wmask), .ls_rdata_o(ls_rdata[0]), .ls_ack_o(ls_ack[0]),
    .bus_sel_o(bus_sel[0]), .bus_wen_o(bus_wen[0]), .bus_addr_o(bus_addr[0]),
    .bus_wdata_o(bus_wdata[0]), .bus_wmask_o(bus_wmask[0]), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack[0]), .busy_o(busy[0]), .err_o(err[0])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic push_fetch(input logic [31:0] addr, input logic [31:0] rdata);
    txn_t t;
    t.is_ls = 1'b0; t.wen = 1'b0; t.addr = addr; t.wdata = 32'h0; t.wmask = 4'b0000;
    t.rdata = rdata;
    sb.push_back(t);
  endtask

  task automatic push_ls(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [31:0] rdata);
    txn_t t;
    t.is_ls = 1'b1; t.wen = wen; t.addr = addr; t.wdata = wdata; t.wmask = wmask;
    t.rdata = rdata;
    sb.push_back(t);
  endtask

  // Acts as the bus slave for DUT d: waits for sel, checks the granted transfer against
  // the queue head, stalls lat cycles, acks, then checks the one-cycle port ack.
  // drop: 0 keep requests, 1 drop the served request, 2 drop both, at the ack cycle.
  task automatic serve(input int d, input int max_wait, input int lat, input int drop);
    txn_t t;
    int   n = 0;
    while (bus_sel[d] !== 1'b1 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    check_bit("sel_rise", bus_sel[d], 1'b1);
    check_bit("busy_in_grant", busy[d], 1'b1);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    t = sb.pop_front();
    check("bus_addr", bus_addr[d], t.addr);
    check_bit("bus_wen", bus_wen[d], t.wen);
    check({28'b0, bus_wmask[d]} == {28'b0, t.wmask} ? "bus_wmask" : "bus_wmask",
          {28'b0, bus_wmask[d]}, {28'b0, t.wmask});
    if (t.is_ls) check("bus_wdata", bus_wdata[d], t.wdata);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check_bit("sel_hold", bus_sel[d], 1'b1);
      check("addr_hold", bus_addr[d], t.addr);
      check("wdata_hold", bus_wdata[d], t.wdata);
      check("ack_early", {30'b0, if_ack[d], ls_ack[d]}, 32'd0);
    end
    bus_rdata  = t.rdata;
    bus_ack[d] = 1'b1;
    @(negedge clk);
    bus_ack[d] = 1'b0;
    bus_rdata  = 32'h0;
    check_bit("sel_drop", bus_sel[d], 1'b0);
    check_bit("busy_drop", busy[d], 1'b0);
    if (t.is_ls) begin
      check_bit("ls_ack", ls_ack[d], 1'b1);
      check_bit("if_ack_quiet", if_ack[d], 1'b0);
      check("ls_rdata", ls_rdata[d], t.rdata);
    end else begin
      check_bit("if_ack", if_ack[d], 1'b1);
      check_bit("ls_ack_quiet", ls_ack[d], 1'b0);
      check("if_rdata", if_rdata[d], t.rdata);
    end
    if (drop == 1) begin
      if (t.is_ls) ls_req[d] = 1'b0;
      else         if_req[d] = 1'b0;
    end else if (drop == 2) begin
      ls_req[d] = 1'b0;
      if_req[d] = 1'b0;
    end
    @(negedge clk);
    if (t.is_ls) begin
      check_bit("ls_ack_single", ls_ack[d], 1'b0);
      check("ls_rdata_hold", ls_rdata[d], t.rdata);
    end else begin
      check_bit("if_ack_single", if_ack[d], 1'b0);
      check("if_rdata_hold", if_rdata[d], t.rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; ls_req[i] = 1'b0; bus_ack[i] = 1'b0;
    end
    ls_wen = 1'b0; if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_wmask = 4'b0000;
    bus_rdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check_bit("rst_sel", bus_sel[1], 1'b0);
    check_bit("rst_busy", busy[1], 1'b0);
    check_bit("rst_err", err[1], 1'b0);
    check_bit("rst_if_ack", if_ack[1], 1'b0);
    check_bit("rst_ls_ack", ls_ack[1], 1'b0);
    check("rst_if_rdata", if_rdata[1], 32'h0);
    check("rst_ls_rdata", ls_rdata[1], 32'h0);
    check("rst_bus_addr", bus_addr[1], 32'h0);
    check_bit("rst_sel_rr", bus_sel[0], 1'b0);
    rst = 1'b0;

    // Bus ack while idle is ignored
    bus_ack[1] = 1'b1;
    @(negedge clk);
    bus_ack[1] = 1'b0;
    @(negedge clk);
    check_bit("idle_ack_if", if_ack[1], 1'b0);
    check_bit("idle_ack_ls", ls_ack[1], 1'b0);
    check_bit("idle_ack_busy", busy[1], 1'b0);

    // Single fetch at minimum latency: sel the cycle after the request
    if_addr = 32'h100;
    push_fetch(32'h100, 32'h0000_0013);
    if_req[1] = 1'b1;
    @(negedge clk);
    serve(1, 0, 0, 1);

    // Store held on the bus for three stall cycles
    ls_wen = 1'b1; ls_addr = 32'h2004; ls_wdata = 32'hA5A5_A5A5; ls_wmask = 4'b1111;
    push_ls(1'b1, 32'h2004, 32'hA5A5_A5A5, 4'b1111, 32'h1111_2222);
    ls_req[1] = 1'b1;
    @(negedge clk);
    serve(1, 0, 3, 1);
    check("if_rdata_kept", if_rdata[1], 32'h0000_0013);

    // Contention under fixed priority: LS, one idle cycle, then IF
    if_addr = 32'h400; ls_wen = 1'b0; ls_addr = 32'h800; ls_wmask = 4'b0011;
    ls_wdata = 32'h0BAD_F00D;
    push_ls(1'b0, 32'h800, 32'h0BAD_F00D, 4'b0011, 32'hCAFE_0001);
    push_fetch(32'h400, 32'hCAFE_0002);
    if_req[1] = 1'b1; ls_req[1] = 1'b1;
    @(negedge clk);
    serve(1, 0, 1, 1);
    serve(1, 0, 0, 1);

    // Request withdrawn mid-transfer still completes
    if_addr = 32'h500;
    push_fetch(32'h500, 32'h5555_AAAA);
    if_req[1] = 1'b1;
    @(negedge clk);
    if_req[1] = 1'b0;
    serve(1, 0, 2, 1);
    @(negedge clk);
    check_bit("no_regrant", bus_sel[1], 1'b0);

    // Reset two cycles after sel rises: sel drops at once, no ack
    if_addr = 32'h300;
    if_req[1] = 1'b1;
    @(negedge clk);
    check_bit("rst_mid_sel_up", bus_sel[1], 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_bit("rst_mid_sel", bus_sel[1], 1'b0);
    check_bit("rst_mid_busy", busy[1], 1'b0);
    check_bit("rst_mid_ack", if_ack[1], 1'b0);
    if_req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_if_rdata", if_rdata[1], 32'h0);
    check("rst_mid_ls_rdata", ls_rdata[1], 32'h0);
    @(negedge clk);
    check_bit("rst_mid_no_ack", if_ack[1], 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout after eight grant cycles with no bus ack
    if_addr = 32'h600;
    if_req[1] = 1'b1;
    @(negedge clk);
    check_bit("to_sel_up", bus_sel[1], 1'b1);
    repeat (7) @(negedge clk);
    check_bit("to_sel_still", bus_sel[1], 1'b1);
    check_bit("to_no_err_yet", err[1], 1'b0);
    if_req[1] = 1'b0;
    @(negedge clk);
    check_bit("to_err", err[1], 1'b1);
    check_bit("to_if_ack", if_ack[1], 1'b1);
    check("to_if_rdata", if_rdata[1], 32'hDEAD_BEEF);
    check_bit("to_sel_drop", bus_sel[1], 1'b0);
    @(negedge clk);
    check_bit("to_err_pulse", err[1], 1'b0);
    check_bit("to_ack_pulse", if_ack[1], 1'b0);
`else
    // Without the timeout the grant waits indefinitely
    if_addr = 32'h600;
    if_req[1] = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);
    check_bit("nto_sel_held", bus_sel[1], 1'b1);
    check_bit("nto_err", err[1], 1'b0);
    check_bit("nto_no_ack", if_ack[1], 1'b0);
    if_req[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_bit("nto_cleared", bus_sel[1], 1'b0);
`endif

    // Round-robin with both requests held across four transfers: LS, IF, LS, IF
    if_addr = 32'h700; ls_wen = 1'b1; ls_addr = 32'h900; ls_wdata = 32'h1234_5678;
    ls_wmask = 4'b0101;
    push_ls(1'b1, 32'h900, 32'h1234_5678, 4'b0101, 32'hAAAA_0001);
    push_fetch(32'h700, 32'hAAAA_0002);
    push_ls(1'b1, 32'h900, 32'h1234_5678, 4'b0101, 32'hAAAA_0003);
    push_fetch(32'h700, 32'hAAAA_0004);
    if_req[0] = 1'b1; ls_req[0] = 1'b1;
    @(negedge clk);
    serve(0, 0, 0, 0);
    serve(0, 0, 1, 0);
    serve(0, 0, 0, 0);
    serve(0, 0, 0, 2);
    check_bit("rr_idle_after", bus_sel[0], 1'b0);
    check_bit("rr_prio_untouched", bus_sel[1], 1'b0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
